// File: rtl/systolic_oe_sorter_if.sv
// -----------------------------------------------------------------------------
// systolic_oe_sorter_if
//
// Bundles the input and output handshakes of systolic_oe_sorter.
//   in_valid / in_ready   : producer offers one N-lane vector plus sort mode
//   in_data               : lane i = in_data[i*DW +: DW]
//   mode                  : 0 = ascending, 1 = descending (sampled at accept)
//   out_valid / out_ready : sorted vector handed to the consumer
//   out_data              : sorted vector, same lane packing as in_data
//   max_out / min_out     : largest / smallest key of the sorted vector
//   busy                  : high while the vector is being sorted
//   phases                : phases executed for the current result
//
// Modports: slave = the sorter, master = the producer/consumer side.
// -----------------------------------------------------------------------------
interface systolic_oe_sorter_if #(
    parameter int N  = 8,
    parameter int DW = 16
);
    localparam int PW = $clog2(N + 1);

    logic                in_valid;
    logic                in_ready;
    logic [N*DW-1:0]     in_data;
    logic                mode;
    logic                out_valid;
    logic                out_ready;
    logic [N*DW-1:0]     out_data;
    logic [DW-1:0]       max_out;
    logic [DW-1:0]       min_out;
    logic                busy;
    logic [PW-1:0]       phases;

    modport slave (
        input  in_valid, in_data, mode, out_ready,
        output in_ready, out_valid, out_data, max_out, min_out, busy, phases
    );

    modport master (
        output in_valid, in_data, mode, out_ready,
        input  in_ready, out_valid, out_data, max_out, min_out, busy, phases
    );
endinterface

// File: rtl/systolic_oe_sorter.sv
// -----------------------------------------------------------------------------
// systolic_oe_sorter
//
// Accepts one N-lane vector, sorts it in place with odd-even transposition
// compare-exchange cells (one phase per clock) and returns the sorted vector
// with max/min taps. Sorting stops early once two consecutive phases make no
// swap, or after N phases at most.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : systolic_oe_sorter_if.slave (handshakes, data, taps, status)
//
// Parameters:
//   N      : lane count (even, >= 2)
//   DW     : key width per lane
//   SIGNED : 1 = keys compared as two's complement, 0 = unsigned
// -----------------------------------------------------------------------------
module systolic_oe_sorter #(
    parameter int N      = 8,
    parameter int DW     = 16,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    systolic_oe_sorter_if.slave   bus
);
    localparam int PW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   lane_q [N];
    logic [DW-1:0]   lane_d [N];
    logic [DW-1:0]   phased [N];
    logic            mode_q, mode_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [PW-1:0]   k;
    logic            prev_zero_q, prev_zero_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   max_q, max_d;
    logic [DW-1:0]   min_q, min_d;
    logic            swapped;

    function automatic logic key_gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (SIGNED != 0)
            return $signed(a) > $signed(b);
        else
            return a > b;
    endfunction

    // One compare-exchange phase applied to the current lanes. Phase k is
    // 1-based: odd k pairs (0,1),(2,3)..., even k pairs (1,2),(3,4)...
    // The pairs are disjoint, so each lane is written by at most one cell.
    // Strict comparison keeps equal keys in place.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            phased[i] = lane_q[i];
        end
        swapped = 1'b0;
        k       = phase_q + PW'(1);
        for (int i = 0; i < N - 1; i++) begin
            if (((i % 2) == 0) == k[0]) begin
                if (mode_q ? key_gt(lane_q[i+1], lane_q[i])
                           : key_gt(lane_q[i], lane_q[i+1])) begin
                    phased[i]   = lane_q[i+1];
                    phased[i+1] = lane_q[i];
                    swapped     = 1'b1;
                end
            end
        end
    end

    // Next-state logic. prev_zero remembers whether the previous phase was
    // swap-free; it is cleared at accept so phase 1 alone can never terminate.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        phase_d     = phase_q;
        prev_zero_d = prev_zero_q;
        out_valid_d = out_valid_q;
        max_d       = max_q;
        min_d       = min_q;
        for (int i = 0; i < N; i++) begin
            lane_d[i] = lane_q[i];
        end

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    for (int i = 0; i < N; i++) begin
                        lane_d[i] = bus.in_data[i*DW +: DW];
                    end
                    mode_d      = bus.mode;
                    phase_d     = '0;
                    prev_zero_d = 1'b0;
                    state_d     = SORT;
                end
            end
            SORT: begin
                for (int i = 0; i < N; i++) begin
                    lane_d[i] = phased[i];
                end
                phase_d     = k;
                prev_zero_d = ~swapped;
                if ((k == PW'(N)) || ((k >= PW'(2)) && prev_zero_q && !swapped)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    max_d       = mode_q ? phased[0]   : phased[N-1];
                    min_d       = mode_q ? phased[N-1] : phased[0];
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            phase_q     <= '0;
            prev_zero_q <= 1'b0;
            out_valid_q <= 1'b0;
            max_q       <= '0;
            min_q       <= '0;
            for (int i = 0; i < N; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            phase_q     <= phase_d;
            prev_zero_q <= prev_zero_d;
            out_valid_q <= out_valid_d;
            max_q       <= max_d;
            min_q       <= min_d;
            for (int i = 0; i < N; i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign bus.out_data[g*DW +: DW] = lane_q[g];
    end

    // in_ready is held low while reset is asserted so nothing is offered
    // an accept that the reset would immediately discard.
    assign bus.in_ready  = (state_q == IDLE) && rst;
    assign bus.out_valid = out_valid_q;
    assign bus.max_out   = max_q;
    assign bus.min_out   = min_q;
    assign bus.busy      = (state_q == SORT);
    assign bus.phases    = phase_q;

endmodule

// File: tb/tb_systolic_oe_sorter.sv
// -----------------------------------------------------------------------------
// tb_systolic_oe_sorter
//
// Drives an unsigned (SIGNED=0) and a signed (SIGNED=1) instance with the same
// stimulus and compares each against a behavioural reference: a plain
// insertion sort for the result, scans for max/min, and an array-level
// odd-even transposition walk for the expected phase count.
// -----------------------------------------------------------------------------
module tb_systolic_oe_sorter;
    localparam int N  = 8;
    localparam int DW = 16;
    localparam int PW = $clog2(N + 1);

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   lat [2];

    systolic_oe_sorter_if #(.N(N), .DW(DW)) ifu ();
    systolic_oe_sorter_if #(.N(N), .DW(DW)) ifs ();

    systolic_oe_sorter #(.N(N), .DW(DW), .SIGNED(0)) dut_u (
        .clk (clk),
        .rst (rst),
        .bus (ifu.slave)
    );

    systolic_oe_sorter #(.N(N), .DW(DW), .SIGNED(1)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (ifs.slave)
    );

    logic [N*DW-1:0] got_data [2];
    logic [DW-1:0]   got_max  [2];
    logic [DW-1:0]   got_min  [2];
    logic [PW-1:0]   got_ph   [2];
    logic            got_ov   [2];
    logic            got_rdy  [2];
    logic            got_busy [2];

    assign got_data[0] = ifu.out_data;   assign got_data[1] = ifs.out_data;
    assign got_max[0]  = ifu.max_out;    assign got_max[1]  = ifs.max_out;
    assign got_min[0]  = ifu.min_out;    assign got_min[1]  = ifs.min_out;
    assign got_ph[0]   = ifu.phases;     assign got_ph[1]   = ifs.phases;
    assign got_ov[0]   = ifu.out_valid;  assign got_ov[1]   = ifs.out_valid;
    assign got_rdy[0]  = ifu.in_ready;   assign got_rdy[1]  = ifs.in_ready;
    assign got_busy[0] = ifu.busy;       assign got_busy[1] = ifs.busy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic logic gt(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sgn);
        if (sgn) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    function automatic logic [N*DW-1:0] sort_ref(input logic [N*DW-1:0] d, input logic m, input logic sgn);
        logic [DW-1:0]   a [N];
        logic [DW-1:0]   t;
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) a[i] = d[i*DW +: DW];
        for (int i = 1; i < N; i++) begin
            t = a[i];
            for (int j = i - 1; j >= 0; j--) begin
                if (gt(a[j], t, sgn)) begin
                    a[j+1] = a[j];
                    a[j]   = t;
                end
            end
        end
        for (int i = 0; i < N; i++) r[i*DW +: DW] = m ? a[N-1-i] : a[i];
        return r;
    endfunction

    function automatic logic [DW-1:0] max_ref(input logic [N*DW-1:0] d, input logic sgn);
        logic [DW-1:0] mx;
        mx = d[DW-1:0];
        for (int i = 1; i < N; i++) if (gt(d[i*DW +: DW], mx, sgn)) mx = d[i*DW +: DW];
        return mx;
    endfunction

    function automatic logic [DW-1:0] min_ref(input logic [N*DW-1:0] d, input logic sgn);
        logic [DW-1:0] mn;
        mn = d[DW-1:0];
        for (int i = 1; i < N; i++) if (gt(mn, d[i*DW +: DW], sgn)) mn = d[i*DW +: DW];
        return mn;
    endfunction

    // Walks the transposition phases on a plain array and returns the phase
    // at which sorting stops (N, or two consecutive swap-free phases).
    function automatic int phases_ref(input logic [N*DW-1:0] d, input logic m, input logic sgn);
        logic [DW-1:0] a [N];
        logic [DW-1:0] t;
        int            swaps;
        bit            prev_clean;
        prev_clean = 1'b0;
        for (int i = 0; i < N; i++) a[i] = d[i*DW +: DW];
        for (int p = 1; p <= N; p++) begin
            swaps = 0;
            for (int i = (p % 2 == 1) ? 0 : 1; i + 1 < N; i += 2) begin
                if (m ? gt(a[i+1], a[i], sgn) : gt(a[i], a[i+1], sgn)) begin
                    t = a[i]; a[i] = a[i+1]; a[i+1] = t;
                    swaps++;
                end
            end
            if (p == N) return p;
            if (p >= 2 && prev_clean && swaps == 0) return p;
            prev_clean = (swaps == 0);
        end
        return N;
    endfunction

    function automatic logic [N*DW-1:0] pack(input int v [N]);
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = v[i][DW-1:0];
        return r;
    endfunction

    function automatic logic [N*DW-1:0] rand_vec();
        logic [N*DW-1:0] r;
        bit              narrow;
        narrow = $urandom_range(0, 1) == 1;
        for (int i = 0; i < N; i++)
            r[i*DW +: DW] = narrow ? DW'($urandom_range(0, 3)) : DW'($urandom);
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_inputs(input logic v, input logic [N*DW-1:0] d, input logic m);
        ifu.in_valid = v; ifu.in_data = d; ifu.mode = m;
        ifs.in_valid = v; ifs.in_data = d; ifs.mode = m;
    endtask

    task automatic set_out_ready(input logic r);
        ifu.out_ready = r;
        ifs.out_ready = r;
    endtask

    // Counts cycles after an accept edge until each instance raises out_valid;
    // -1 means it never did within the budget.
    task automatic collect_latency();
        lat[0] = -1;
        lat[1] = -1;
        for (int c = 1; c <= N + 3; c++) begin
            @(posedge clk); #1;
            if (got_ov[0] && lat[0] < 0) lat[0] = c;
            if (got_ov[1] && lat[1] < 0) lat[1] = c;
        end
    endtask

    task automatic run_vec(input logic [N*DW-1:0] d, input logic m);
        @(negedge clk);
        set_out_ready(1'b0);
        set_inputs(1'b1, d, m);
        @(posedge clk); #1;
        set_inputs(1'b0, '0, 1'b0);
        collect_latency();
    endtask

    task automatic release_out();
        @(negedge clk);
        set_out_ready(1'b1);
        @(posedge clk); #1;
        set_out_ready(1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        set_inputs(1'b0, '0, 1'b0);
        set_out_ready(1'b0);
        #12;
        for (int s = 0; s < 2; s++) begin
            checks += 4;
            if (got_ov[s] !== 1'b0) begin errors++; $display("[TB] FAIL reset out_valid dut%0d: got %b want 0", s, got_ov[s]); end
            if (got_busy[s] !== 1'b0) begin errors++; $display("[TB] FAIL reset busy dut%0d: got %b want 0", s, got_busy[s]); end
            if (got_ph[s] !== '0) begin errors++; $display("[TB] FAIL reset phases dut%0d: got %0d want 0", s, got_ph[s]); end
            if (got_data[s] !== '0) begin errors++; $display("[TB] FAIL reset lanes dut%0d: got %h want 0", s, got_data[s]); end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (got_rdy[s] !== 1'b1) begin errors++; $display("[TB] FAIL reset in_ready dut%0d: got %b want 1", s, got_rdy[s]); end
        end
    endtask

    task automatic test_directed();
        int              v [N];
        logic [N*DW-1:0] d;
        logic            m;
        logic [N*DW-1:0] exp_d;
        int              exp_k;
        for (int t = 0; t < 4; t++) begin
            case (t)
                0: begin v = '{7, 6, 5, 4, 3, 2, 1, 0}; m = 1'b0; end
                1: begin v = '{0, 1, 2, 3, 4, 5, 6, 7}; m = 1'b0; end
                2: begin v = '{3, 9, 1, 9, 0, 4, 4, 2}; m = 1'b1; end
                default: begin v = '{32'h0001, 32'hFFFF, 32'h8000, 32'h7FFF, 0, 0, 0, 0}; m = 1'b0; end
            endcase
            d = pack(v);
            run_vec(d, m);
            for (int s = 0; s < 2; s++) begin
                exp_d = sort_ref(d, m, s[0]);
                exp_k = phases_ref(d, m, s[0]);
                checks += 4;
                if (lat[s] !== exp_k || got_ph[s] !== PW'(exp_k)) begin errors++; $display("[TB] FAIL directed%0d latency dut%0d: lat=%0d phases=%0d want %0d", t, s, lat[s], got_ph[s], exp_k); end
                if (got_data[s] !== exp_d) begin errors++; $display("[TB] FAIL directed%0d data dut%0d: got %h want %h", t, s, got_data[s], exp_d); end
                if (got_max[s] !== max_ref(d, s[0])) begin errors++; $display("[TB] FAIL directed%0d max dut%0d: got %h want %h", t, s, got_max[s], max_ref(d, s[0])); end
                if (got_min[s] !== min_ref(d, s[0])) begin errors++; $display("[TB] FAIL directed%0d min dut%0d: got %h want %h", t, s, got_min[s], min_ref(d, s[0])); end
            end
            release_out();
        end
    endtask

    task automatic test_random();
        logic [N*DW-1:0] d;
        logic            m;
        logic [N*DW-1:0] exp_d;
        int              exp_k;
        for (int t = 0; t < 24; t++) begin
            d = rand_vec();
            m = 1'($urandom_range(0, 1));
            run_vec(d, m);
            for (int s = 0; s < 2; s++) begin
                exp_d = sort_ref(d, m, s[0]);
                exp_k = phases_ref(d, m, s[0]);
                checks += 4;
                if (lat[s] !== exp_k || got_ph[s] !== PW'(exp_k)) begin errors++; $display("[TB] FAIL random%0d latency dut%0d: lat=%0d phases=%0d want %0d", t, s, lat[s], got_ph[s], exp_k); end
                if (got_data[s] !== exp_d) begin errors++; $display("[TB] FAIL random%0d data dut%0d: got %h want %h", t, s, got_data[s], exp_d); end
                if (got_max[s] !== max_ref(d, s[0])) begin errors++; $display("[TB] FAIL random%0d max dut%0d: got %h want %h", t, s, got_max[s], max_ref(d, s[0])); end
                if (got_min[s] !== min_ref(d, s[0])) begin errors++; $display("[TB] FAIL random%0d min dut%0d: got %h want %h", t, s, got_min[s], min_ref(d, s[0])); end
            end
            release_out();
        end
    endtask

    task automatic test_back_to_back();
        logic [N*DW-1:0] d;
        logic [N*DW-1:0] exp_d;
        int              exp_k;
        d = rand_vec();
        run_vec(d, 1'b0);
        release_out();
        for (int s = 0; s < 2; s++) begin
            checks += 2;
            if (got_ov[s] !== 1'b0) begin errors++; $display("[TB] FAIL b2b release out_valid dut%0d: got %b want 0", s, got_ov[s]); end
            if (got_rdy[s] !== 1'b1) begin errors++; $display("[TB] FAIL b2b release in_ready dut%0d: got %b want 1", s, got_rdy[s]); end
        end
        d = rand_vec();
        run_vec(d, 1'b1);
        for (int s = 0; s < 2; s++) begin
            exp_d = sort_ref(d, 1'b1, s[0]);
            exp_k = phases_ref(d, 1'b1, s[0]);
            checks += 2;
            if (lat[s] !== exp_k) begin errors++; $display("[TB] FAIL b2b latency dut%0d: got %0d want %0d", s, lat[s], exp_k); end
            if (got_data[s] !== exp_d) begin errors++; $display("[TB] FAIL b2b data dut%0d: got %h want %h", s, got_data[s], exp_d); end
        end
        release_out();
    endtask

    task automatic test_backpressure();
        logic [N*DW-1:0] d1;
        logic [N*DW-1:0] d2;
        logic [N*DW-1:0] exp_d;
        int              exp_k;
        d1 = rand_vec();
        d2 = rand_vec();
        run_vec(d1, 1'b0);
        @(negedge clk);
        set_inputs(1'b1, d2, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            for (int s = 0; s < 2; s++) begin
                checks += 4;
                if (got_data[s] !== sort_ref(d1, 1'b0, s[0])) begin errors++; $display("[TB] FAIL hold data dut%0d cyc%0d: got %h want %h", s, c, got_data[s], sort_ref(d1, 1'b0, s[0])); end
                if (got_max[s] !== max_ref(d1, s[0])) begin errors++; $display("[TB] FAIL hold max dut%0d cyc%0d: got %h want %h", s, c, got_max[s], max_ref(d1, s[0])); end
                if (got_rdy[s] !== 1'b0) begin errors++; $display("[TB] FAIL hold in_ready dut%0d cyc%0d: got %b want 0", s, c, got_rdy[s]); end
                if (got_ov[s] !== 1'b1) begin errors++; $display("[TB] FAIL hold out_valid dut%0d cyc%0d: got %b want 1", s, c, got_ov[s]); end
            end
        end
        @(negedge clk);
        set_out_ready(1'b1);
        @(posedge clk); #1;
        set_out_ready(1'b0);
        for (int s = 0; s < 2; s++) begin
            checks += 2;
            if (got_ov[s] !== 1'b0) begin errors++; $display("[TB] FAIL bp release out_valid dut%0d: got %b want 0", s, got_ov[s]); end
            if (got_rdy[s] !== 1'b1) begin errors++; $display("[TB] FAIL bp release in_ready dut%0d: got %b want 1", s, got_rdy[s]); end
        end
        // in_valid is still high with d2, so the next edge is the accept.
        @(posedge clk); #1;
        set_inputs(1'b0, '0, 1'b0);
        collect_latency();
        for (int s = 0; s < 2; s++) begin
            exp_d = sort_ref(d2, 1'b1, s[0]);
            exp_k = phases_ref(d2, 1'b1, s[0]);
            checks += 2;
            if (lat[s] !== exp_k) begin errors++; $display("[TB] FAIL bp next latency dut%0d: got %0d want %0d", s, lat[s], exp_k); end
            if (got_data[s] !== exp_d) begin errors++; $display("[TB] FAIL bp next data dut%0d: got %h want %h", s, got_data[s], exp_d); end
        end
        release_out();
    endtask

    task automatic test_reset_mid_sort();
        int              v [N];
        logic [N*DW-1:0] d;
        logic [N*DW-1:0] exp_d;
        int              exp_k;
        bit              spurious [2];
        v = '{7, 6, 5, 4, 3, 2, 1, 0};
        @(negedge clk);
        set_inputs(1'b1, pack(v), 1'b0);
        @(posedge clk); #1;
        set_inputs(1'b0, '0, 1'b0);
        @(posedge clk);
        @(posedge clk); #2;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (got_busy[s] !== 1'b1) begin errors++; $display("[TB] FAIL midsort busy dut%0d: got %b want 1", s, got_busy[s]); end
        end
        rst = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            checks += 3;
            if (got_ov[s] !== 1'b0) begin errors++; $display("[TB] FAIL midsort rst out_valid dut%0d: got %b want 0", s, got_ov[s]); end
            if (got_busy[s] !== 1'b0) begin errors++; $display("[TB] FAIL midsort rst busy dut%0d: got %b want 0", s, got_busy[s]); end
            if (got_data[s] !== '0) begin errors++; $display("[TB] FAIL midsort rst lanes dut%0d: got %h want 0", s, got_data[s]); end
        end
        @(negedge clk);
        rst = 1'b1;
        spurious[0] = 1'b0;
        spurious[1] = 1'b0;
        for (int c = 0; c < N + 2; c++) begin
            @(posedge clk); #1;
            if (got_ov[0]) spurious[0] = 1'b1;
            if (got_ov[1]) spurious[1] = 1'b1;
        end
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (spurious[s]) begin errors++; $display("[TB] FAIL midsort discarded output dut%0d: out_valid seen want none", s); end
        end
        d = rand_vec();
        run_vec(d, 1'b0);
        for (int s = 0; s < 2; s++) begin
            exp_d = sort_ref(d, 1'b0, s[0]);
            exp_k = phases_ref(d, 1'b0, s[0]);
            checks += 2;
            if (lat[s] !== exp_k) begin errors++; $display("[TB] FAIL post-reset latency dut%0d: got %0d want %0d", s, lat[s], exp_k); end
            if (got_data[s] !== exp_d) begin errors++; $display("[TB] FAIL post-reset data dut%0d: got %h want %h", s, got_data[s], exp_d); end
        end
        release_out();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_sort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
